program_loader: RTL

// Writes a program image into the 16-bit RISC processor's instruction/data memory. The control unit only fetches and reads that memory.

---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Host byte link plus memory-write and status outputs of the program loader.
interface program_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_adr;
  logic [15:0] mem_dout;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  status;

  // Loader side: consumes bytes, drives memory and status.
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_adr, mem_dout, mem_we, cpu_hold, busy, done, error, status
  );

  // Host / observer side.
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_adr, mem_dout, mem_we, cpu_hold, busy, done, error, status
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream, writes big-endian 16-bit
// words to consecutive addresses from BASE_ADR, verifies an 8-bit checksum
// and holds the CPU in reset until a frame loads correctly.
module program_loader #(
  parameter logic [15:0] BASE_ADR  = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  whi_q, whi_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] dout_q, dout_d;
  logic        rdy;
  logic        accept;
  logic [15:0] cnt_new;

  assign rdy     = (state_q != S_WRITE);
  assign accept  = bus.rx_valid && rdy;
  assign cnt_new = {cnt_q[15:8], bus.rx_data};

  // State and datapath registers; reset returns to IDLE with cleared counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      whi_q   <= '0;
      adr_q   <= BASE_ADR;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      whi_q   <= whi_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and datapath updates driven by accepted bytes.
  // Address/data are captured with the LO byte so they are valid during
  // the WRITE cycle and then simply hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    whi_d   = whi_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && bus.rx_data == SYNC_BYTE) begin
          state_d = S_CNT_HI;
          sum_d   = '0;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          cnt_d[15:8] = bus.rx_data;
          sum_d       = sum_q + bus.rx_data;
          state_d     = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_d  = cnt_new;
          sum_d  = sum_q + bus.rx_data;
          idx_d  = '0;
          if (cnt_new == '0 || {1'b0, cnt_new} > MAX_W) state_d = S_ERROR;
          else                                          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          whi_d   = bus.rx_data;
          sum_d   = sum_q + bus.rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          sum_d   = sum_q + bus.rx_data;
          adr_d   = BASE_ADR + idx_q;
          dout_d  = {whi_q, bus.rx_data};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if (idx_q + 16'd1 == cnt_q) state_d = S_CHECK;
        else                        state_d = S_DATA_HI;
      end
      S_CHECK: begin
        if (accept) state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.rx_ready = rdy;
    bus.mem_we   = (state_q == S_WRITE);
    bus.mem_adr  = adr_q;
    bus.mem_dout = dout_q;
    bus.done     = (state_q == S_DONE);
    bus.error    = (state_q == S_ERROR);
    bus.cpu_hold = (state_q != S_DONE);
    bus.busy     = 1'b0;
    bus.status   = 8'h01;
    unique case (state_q)
      S_IDLE:    bus.status = 8'h01;
      S_CNT_HI:  begin bus.status = 8'h02; bus.busy = 1'b1; end
      S_CNT_LO:  begin bus.status = 8'h03; bus.busy = 1'b1; end
      S_DATA_HI: begin bus.status = 8'h04; bus.busy = 1'b1; end
      S_DATA_LO: begin bus.status = 8'h05; bus.busy = 1'b1; end
      S_WRITE:   begin bus.status = 8'h08; bus.busy = 1'b1; end
      S_CHECK:   begin bus.status = 8'h10; bus.busy = 1'b1; end
      S_DONE:    bus.status = 8'h80;
      S_ERROR:   bus.status = 8'hF0;
      default:   bus.status = 8'h01;
    endcase
  end

endmodule
